// File: rtl/ubio_fetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words ahead of the uBio core,
// tags them with their PC, and hands them over a valid/ready interface.
module ubio_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned LW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          ins_valid,
  output logic [DW-1:0] ins_data,
  output logic [AW-1:0] ins_pc,
  input  logic          ins_ready,
  input  logic          flush,
  input  logic [AW-1:0] flush_pc,
  input  logic          halt,
  output logic [LW-1:0] level
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_req;
  logic          w_req_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [AW-1:0] r_fpc;
  logic [AW-1:0] w_fpc_nxt;
  logic [AW-1:0] w_fpc_inc;

  logic [DW-1:0] r_fifo_data [DEPTH];
  logic [AW-1:0] r_fifo_pc   [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_lvl_next;
  logic          w_can_issue;

  assign w_push      = (r_state == S_REQ) && mem_ack && !flush;
  assign w_pop       = ins_ready && (r_level != '0);
  assign w_lvl_next  = r_level + LW'(w_push) - LW'(w_pop);
  assign w_can_issue = !halt && (w_lvl_next < LW'(DEPTH));
  assign w_fpc_inc   = r_fpc + AW'(2);

  // Fetch FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_fpc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_fpc   <= w_fpc_nxt;
    end
  end

  // Next-state and request decision; a flush always wins over a fresh request
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_fpc_nxt   = r_fpc;
    case (r_state)
      S_IDLE: begin
        if (!flush && w_can_issue) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fpc;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (flush) begin
          if (mem_ack) begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DROP;
          end
        end else if (mem_ack) begin
          w_fpc_nxt = w_fpc_inc;
          if (w_can_issue) begin
            w_addr_nxt = w_fpc_inc;
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (flush) begin
      w_fpc_nxt = {flush_pc[AW-1:1], 1'b0};
    end
  end

  // FIFO pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_level <= w_lvl_next;
    end
  end

  // FIFO storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_fifo_data[r_wptr] <= mem_rdata;
      r_fifo_pc[r_wptr]   <= r_fpc;
    end
  end

  assign mem_req   = r_req;
  assign mem_addr  = r_addr;
  assign ins_valid = (r_level != '0);
  assign ins_data  = r_fifo_data[r_rptr];
  assign ins_pc    = r_fifo_pc[r_rptr];
  assign level     = r_level;

endmodule

// File: tb/tb_ubio_fetch_queue.sv
// Scoreboard bench for ubio_fetch_queue: a memory model with programmable ack
// latency queues expected {pc,data} per accepted word; pops are compared in order.
module tb_ubio_fetch_queue;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 3;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          ins_valid;
  logic [DW-1:0] ins_data;
  logic [AW-1:0] ins_pc;
  logic          ins_ready;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic          halt;
  logic [LW-1:0] level;

  ubio_fetch_queue dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .ins_valid(ins_valid),
    .ins_data (ins_data),
    .ins_pc   (ins_pc),
    .ins_ready(ins_ready),
    .flush    (flush),
    .flush_pc (flush_pc),
    .halt     (halt),
    .level    (level)
  );

  int            n_chk = 0;
  int            n_err = 0;
  exp_t          q[$];
  logic [AW-1:0] exp_next_pc = '0;
  logic [DW-1:0] data_xor = '0;
  bit            stale = 1'b0;
  bit            pushed_now = 1'b0;
  bit            pending = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  int            lat = 0;
  int            wcnt = 0;
  int            ack_cnt = 0;
  int            pop_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_flush(input logic [AW-1:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    step(1);
    flush    = 1'b0;
  endtask

  // Memory model: ack after 'lat' extra cycles, data = addr ^ data_xor
  always begin
    @(posedge clk);
    #1;
    pushed_now = 1'b0;
    mem_ack    = 1'b0;
    if (!rst) begin
      wcnt    = 0;
      pending = 1'b0;
    end else if (mem_req) begin
      if (pending) check("addr_hold", 32'(mem_addr), 32'(hold_addr));
      if (wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ data_xor;
        wcnt      = 0;
        pending   = 1'b0;
        if (stale) begin
          stale = 1'b0;
        end else begin
          check("mem_addr", 32'(mem_addr), 32'(exp_next_pc));
          q.push_back('{pc: exp_next_pc, data: exp_next_pc ^ data_xor});
          exp_next_pc = exp_next_pc + 16'd2;
          ack_cnt++;
          pushed_now = 1'b1;
        end
      end else begin
        pending   = 1'b1;
        hold_addr = mem_addr;
        wcnt++;
      end
    end else begin
      if (pending) check("req_hold", 32'(mem_req), 32'd1);
      pending = 1'b0;
      wcnt    = 0;
    end
  end

  // Output scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    int   exp_lvl;
    if (!rst) begin
      q.delete();
      exp_next_pc = '0;
      stale       = 1'b0;
    end else begin
      exp_lvl = q.size() - (pushed_now ? 1 : 0);
      check("level", 32'(level), 32'(exp_lvl));
      check("ins_valid", 32'(ins_valid), 32'(exp_lvl != 0));
      if (ins_valid && ins_ready) begin
        if (q.size() == 0) begin
          check("pop_empty", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("ins_pc", 32'(ins_pc), 32'(e.pc));
          check("ins_data", 32'(ins_data), 32'(e.data));
          pop_cnt++;
        end
      end
      if (flush) begin
        q.delete();
        exp_next_pc = flush_pc & 16'hFFFE;
        stale       = mem_req && !mem_ack;
      end
    end
  end

  initial begin
    int acks_saved;
    int pops_saved;
    int i;
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ins_ready = 1'b0;
    flush     = 1'b0;
    flush_pc  = '0;
    halt      = 1'b0;

    step(2);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_valid", 32'(ins_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    rst = 1'b1;

    // T1: zero-wait fill with core stalled
    lat = 0;
    step(8);
    check("t1_req", 32'(mem_req), 32'd0);
    check("t1_level", 32'(level), 32'd4);
    check("t1_acks", 32'(ack_cnt), 32'd4);
    check("t1_pc", 32'(ins_pc), 32'h0);
    check("t1_data", 32'(ins_data), 32'h0);

    // T2: continuous drain, 2-cycle ack latency
    data_xor  = 16'h5A5A;
    lat       = 2;
    ins_ready = 1'b1;
    step(40);

    // T3: flush while request to 0x0006 pending, stale ack 3 cycles later
    rst = 1'b0;
    step(1);
    rst       = 1'b1;
    ins_ready = 1'b0;
    lat       = 3;
    for (i = 0; i < 60 && !(mem_req && mem_addr == 16'h0006); i++) step(1);
    check("t3_wait6", 32'(mem_req && mem_addr == 16'h0006), 32'd1);
    do_flush(16'h0031);
    check("t3_level", 32'(level), 32'd0);
    for (i = 0; i < 40 && !ins_valid; i++) step(1);
    check("t3_valid", 32'(ins_valid), 32'd1);
    check("t3_pc", 32'(ins_pc), 32'h0030);
    ins_ready = 1'b1;
    step(20);

    // T4: flush and ack in the same cycle
    rst = 1'b0;
    step(1);
    rst       = 1'b1;
    ins_ready = 1'b0;
    lat       = 1;
    for (i = 0; i < 60 && !(mem_ack && mem_addr == 16'h0004); i++) step(1);
    check("t4_wait", 32'(mem_ack && mem_addr == 16'h0004), 32'd1);
    do_flush(16'h0100);
    check("t4_level", 32'(level), 32'd0);
    check("t4_valid", 32'(ins_valid), 32'd0);
    ins_ready = 1'b1;
    step(15);

    // T5: PC wrap-around
    lat        = 0;
    pops_saved = pop_cnt;
    do_flush(16'hFFFC);
    step(10);
    check("t5_pops", 32'(pop_cnt - pops_saved >= 4), 32'd1);

    // T6: halt with a pending request, flush under halt, resume
    rst = 1'b0;
    step(1);
    rst       = 1'b1;
    ins_ready = 1'b0;
    lat       = 3;
    for (i = 0; i < 40 && !(mem_req && !mem_ack); i++) step(1);
    check("t6_pend", 32'(mem_req && !mem_ack), 32'd1);
    halt = 1'b1;
    for (i = 0; i < 40 && !mem_ack; i++) step(1);
    check("t6_ack", 32'(mem_ack), 32'd1);
    step(2);
    acks_saved = ack_cnt;
    check("t6_req_off", 32'(mem_req), 32'd0);
    check("t6_level", 32'(level), 32'(q.size()));
    ins_ready = 1'b1;
    step(8);
    check("t6_drain_req", 32'(mem_req), 32'd0);
    check("t6_drain_lvl", 32'(level), 32'd0);
    check("t6_no_acks", 32'(ack_cnt), 32'(acks_saved));
    do_flush(16'h0200);
    step(4);
    check("t6_flush_req", 32'(mem_req), 32'd0);
    halt = 1'b0;
    step(1);
    check("t6_resume_req", 32'(mem_req), 32'd1);
    check("t6_resume_addr", 32'(mem_addr), 32'h0200);
    step(20);

    // Reset in the middle of an outstanding request
    for (i = 0; i < 40 && !(mem_req && !mem_ack); i++) step(1);
    check("rst_mid_pend", 32'(mem_req && !mem_ack), 32'd1);
    rst = 1'b0;
    step(1);
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'd0);
    check("rst_mid_valid", 32'(ins_valid), 32'd0);
    check("rst_mid_level", 32'(level), 32'd0);
    rst = 1'b1;
    lat = 0;
    step(12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
